// File: rtl/fifo_flags_if.sv
// fifo_flags_if: handshake/status bundle for the fifo_flags buffer.
//   master : producer/consumer side (drives flush, wr, w_data, rd, clr_err)
//   slave  : FIFO side (drives r_data, empty, full, almost_empty,
//            almost_full, count, overflow, underflow)
// Parameters B (data width) and W (address width) must match the FIFO.
interface fifo_flags_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         flush;
  logic         wr;
  logic [B-1:0] w_data;
  logic         rd;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output flush, wr, w_data, rd, clr_err,
    input  r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wr, w_data, rd, clr_err,
    output r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous show-ahead FIFO with occupancy count,
// programmable almost-full/almost-empty flags and synchronous flush.
//
// Ports:
//   clk      in  single clock, posedge
//   reset_n  in  asynchronous active-low reset
//   bus      fifo_flags_if.slave (write/read handshake, status flags)
//
// Optional feature: define FIFO_ERR_FLAGS_EN to get sticky overflow /
// underflow flags cleared by clr_err. Undefined: both tied to 0.
//
// No FSM: the only state is pointers, count and registered flags.
module fifo_flags #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  fifo_flags_if.slave   bus
);

  localparam int         DEPTH    = 2 ** W;
  localparam logic [W:0] LP_DEPTH = (W+1)'(DEPTH);
  localparam logic [W:0] LP_AF    = (W+1)'(AF_LEVEL);
  localparam logic [W:0] LP_AE    = (W+1)'(AE_LEVEL);

  logic [B-1:0] r_mem [DEPTH];
  logic [W-1:0] r_wptr;
  logic [W-1:0] r_rptr;
  logic [W:0]   r_count;
  logic         r_empty;
  logic         r_full;
  logic         r_almost_empty;
  logic         r_almost_full;

  logic         w_wr_acc;
  logic         w_rd_acc;
  logic [W:0]   w_count_next;

  // Acceptance uses registered flags only, so wr/rd never reach a flag
  // or count output combinationally. A write while full is allowed only
  // when a read frees a slot on the same edge.
  assign w_wr_acc = bus.wr & (~r_full | bus.rd);
  assign w_rd_acc = bus.rd & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    if (bus.flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + {{W{1'b0}}, w_wr_acc} - {{W{1'b0}}, w_rd_acc};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + W'(1);
        if (w_rd_acc) r_rptr <= r_rptr + W'(1);
      end
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_full         <= (w_count_next == LP_DEPTH);
      r_almost_empty <= (w_count_next <= LP_AE);
      r_almost_full  <= (w_count_next >= LP_AF);
    end
  end

  // Storage is neither reset nor flushed; only the pointers move.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !bus.flush) begin
      r_mem[r_wptr] <= bus.w_data;
    end
  end

  assign bus.r_data       = r_mem[r_rptr];
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.count        = r_count;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // clr_err beats a same-cycle set; flush leaves the sticky bits alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clr_err) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr && r_full && !bus.rd)  r_overflow  <= 1'b1;
      if (bus.rd && r_empty && !bus.wr) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  logic w_unused;
  assign w_unused      = bus.clr_err;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: table-driven check of fifo_flags (B=8, W=2, AF=3, AE=1)
// with a data scoreboard queue for read ordering.
module tb_fifo_flags;

  localparam int B     = 8;
  localparam int W     = 2;
  localparam int DEPTH = 4;

`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;

  fifo_flags_if #(.B(B), .W(W)) bus ();

  fifo_flags #(.B(B), .W(W), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       f, w, r, c;
    logic [7:0] d;
    int         cnt;
    logic       e, fu, ae, af, ov, uf;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag, input int cnt, input logic e,
                           input logic fu, input logic ae, input logic af,
                           input logic ov, input logic uf);
    chk({tag, ".count"}, int'(bus.count), cnt);
    chk({tag, ".empty"}, int'(bus.empty), int'(e));
    chk({tag, ".full"},  int'(bus.full),  int'(fu));
    chk({tag, ".aempty"}, int'(bus.almost_empty), int'(ae));
    chk({tag, ".afull"},  int'(bus.almost_full),  int'(af));
    chk({tag, ".ovf"}, int'(bus.overflow),  int'(ov & ERR_EN));
    chk({tag, ".udf"}, int'(bus.underflow), int'(uf & ERR_EN));
  endtask

  // One clock of stimulus. Called just after a posedge; returns #1 after
  // the next posedge with inputs idle again.
  task automatic step(input logic f, input logic w, input logic r,
                      input logic c, input logic [7:0] d);
    logic wacc, racc;
    bus.flush   = f;
    bus.wr      = w;
    bus.rd      = r;
    bus.clr_err = c;
    bus.w_data  = d;
    wacc = w & ((sb.size() < DEPTH) | r);
    racc = r & (sb.size() > 0);
    if (f) begin
      wacc = 1'b0;
      racc = 1'b0;
    end
    #1;
    if (racc) chk("rdata", int'(bus.r_data), int'(sb[0]));
    @(posedge clk);
    #1;
    if (f) sb.delete();
    else begin
      if (racc) void'(sb.pop_front());
      if (wacc) sb.push_back(d);
    end
    bus.flush   = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    bus.w_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            f  w  r  c  d      cnt e fu ae af ov uf
    tbl[0]  = '{0, 1, 0, 0, 8'hA1, 1, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 8'hA2, 2, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 8'hA3, 3, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 8'hA4, 4, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 8'hFF, 4, 0, 1, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 1, 8'h00, 4, 0, 1, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 8'hB0, 4, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 8'h00, 3, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 0, 8'h5C, 1, 0, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 8'h11, 1, 0, 0, 1, 0, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 0, 0, 8'h33, 3, 0, 0, 0, 1, 0, 0};
    tbl[18] = '{1, 1, 0, 0, 8'h44, 0, 1, 0, 1, 0, 0, 0};
    tbl[19] = '{0, 1, 0, 0, 8'h55, 1, 0, 0, 1, 0, 0, 0};
    tbl[20] = '{0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0};

    bus.flush   = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    bus.w_data  = '0;
    reset_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_flags("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk_flags($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].e, tbl[i].fu,
                tbl[i].ae, tbl[i].af, tbl[i].ov, tbl[i].uf);
    end

    // Pointer wrap: hold two words while streaming ten simultaneous pairs.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      chk_flags($sformatf("wrap%0d", i), 2, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_flags("drain", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a clock period.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hC1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hC2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
    chk_flags("prerst", 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_flags("asyncrst", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
    chk_flags("postrst", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_flags("postrd", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
